// File: rtl/vout_timing_gen.sv
// -----------------------------------------------------------------------------
// vout_timing_gen
//
// Video output timing generator. Produces the display raster (hs/vs/de) on
// vout_clk, pulls 24-bit RGB pixels from the frame-buffer read controller
// during active video, and registers them onto the output pins together with
// delay-matched syncs.
//
// Optional feature macro: VOUT_UNDERFLOW_STAT_EN
//   defined   : pops that hit an empty FIFO are replaced by BLANK_COLOR and
//               reported through underflow / underflow_cnt.
//   undefined : vout_data passes through unmodified, fifo_rdempty is ignored,
//               underflow and underflow_cnt are held at 0.
//
// Ports
//   vout_clk       in   pixel clock (only clock)
//   rst            in   asynchronous active-high reset
//   enable         in   run request, sampled only at frame boundaries
//   vout_vs        out  active-high vsync to the controller (not delayed)
//   vout_rd_req    out  pixel pop request to the controller
//   vout_data      in   pixel from the controller, valid the cycle after a pop
//   fifo_rdempty   in   controller FIFO empty, sampled with vout_rd_req
//   vout_width     out  constant H_ACTIVE
//   vout_height    out  constant V_ACTIVE
//   out_hs/out_vs  out  registered syncs, polarity HS_POL / VS_POL
//   out_de         out  registered data enable
//   out_data       out  registered pixel, 0 when out_de is low
//   underflow      out  set for the current frame if any pop hit empty
//   underflow_cnt  out  saturating count of underflowed pixels
//   dbg_state      out  current FSM state (IDLE=0, RUN_BLANK=1, RUN=2)
// -----------------------------------------------------------------------------
module vout_timing_gen #(
  parameter int          H_ACTIVE    = 1024,
  parameter int          H_FP        = 24,
  parameter int          H_SYNC      = 136,
  parameter int          H_BP        = 160,
  parameter int          V_ACTIVE    = 768,
  parameter int          V_FP        = 3,
  parameter int          V_SYNC      = 6,
  parameter int          V_BP        = 29,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter logic [23:0] BLANK_COLOR = 24'h000000
) (
  input  logic        vout_clk,
  input  logic        rst,
  input  logic        enable,
  output logic        vout_vs,
  output logic        vout_rd_req,
  input  logic [23:0] vout_data,
  input  logic        fifo_rdempty,
  output logic [11:0] vout_width,
  output logic [11:0] vout_height,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [23:0] out_data,
  output logic        underflow,
  output logic [15:0] underflow_cnt,
  output logic [1:0]  dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Pop handshake with the controller: vout_rd_req high in cycle N pops one
  // pixel, which is presented on vout_data in cycle N+1. There is no
  // back-pressure; fifo_rdempty sampled in cycle N only marks the pixel bad.

  logic [1:0]  state_q, state_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;

  // Stage 0: registered decode, aligned with the counters.
  logic rd_req_q, rd_req_d;
  logic hs0_q, hs0_d;
  logic vs0_q, vs0_d;
  logic first0_q, first0_d;
  // Stage 1: pixel data is valid on vout_data.
  logic de1_q, de1_d;
  logic hs1_q, hs1_d;
  logic vs1_q, vs1_d;
  logic first1_q, first1_d;
  logic emp1_q, emp1_d;
  // Stage 2: output pins.
  logic        out_de_q, out_de_d;
  logic        out_hs_q, out_hs_d;
  logic        out_vs_q, out_vs_d;
  logic [23:0] out_data_q, out_data_d;
  logic        underflow_q, underflow_d;
  logic [15:0] underflow_cnt_q, underflow_cnt_d;

  logic emp_s;
  logic uf_hit;

`ifdef VOUT_UNDERFLOW_STAT_EN
  assign emp_s = fifo_rdempty;
`else
  logic unused_rdempty;
  assign unused_rdempty = fifo_rdempty;
  assign emp_s          = 1'b0;
`endif

  // FSM and raster counters.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable) state_d = ST_BLANK;
      end
      ST_BLANK, ST_RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
          // enable only matters on the last pixel of the frame
          if (v_cnt_q == V_LAST) state_d = enable ? ST_RUN : ST_IDLE;
        end else begin
          h_cnt_d = h_cnt_q + 12'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    endcase
  end

  // Decode is taken from the next counter values so that the registered
  // flags line up with the counters they describe.
  always_comb begin
    rd_req_d = (state_d == ST_RUN) && (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    hs0_d    = (state_d != ST_IDLE) && (h_cnt_d >= HS_START) && (h_cnt_d < HS_END);
    vs0_d    = (state_d != ST_IDLE) && (v_cnt_d >= VS_START) && (v_cnt_d < VS_END);
    first0_d = rd_req_d && (h_cnt_d == 12'd0) && (v_cnt_d == 12'd0);
  end

  // Pixel pipeline: syncs travel with the data so out_hs/out_vs/out_de agree.
  always_comb begin
    de1_d      = rd_req_q;
    hs1_d      = hs0_q;
    vs1_d      = vs0_q;
    first1_d   = first0_q;
    emp1_d     = rd_req_q & emp_s;
    out_de_d   = de1_q;
    out_hs_d   = hs1_q ? HS_POL : ~HS_POL;
    out_vs_d   = vs1_q ? VS_POL : ~VS_POL;
    out_data_d = '0;
    if (de1_q) out_data_d = emp1_q ? BLANK_COLOR : vout_data;
  end

  assign uf_hit = de1_q & emp1_q;

  always_comb begin
`ifdef VOUT_UNDERFLOW_STAT_EN
    // The first pixel of a frame restarts the flag with its own status.
    if (de1_q && first1_q) underflow_d = uf_hit;
    else                   underflow_d = underflow_q | uf_hit;
    underflow_cnt_d = underflow_cnt_q;
    if (uf_hit && (underflow_cnt_q != 16'hFFFF)) underflow_cnt_d = underflow_cnt_q + 16'd1;
`else
    underflow_d     = 1'b0;
    underflow_cnt_d = '0;
`endif
  end

  always_ff @(posedge vout_clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      h_cnt_q         <= '0;
      v_cnt_q         <= '0;
      rd_req_q        <= 1'b0;
      hs0_q           <= 1'b0;
      vs0_q           <= 1'b0;
      first0_q        <= 1'b0;
      de1_q           <= 1'b0;
      hs1_q           <= 1'b0;
      vs1_q           <= 1'b0;
      first1_q        <= 1'b0;
      emp1_q          <= 1'b0;
      out_de_q        <= 1'b0;
      out_hs_q        <= ~HS_POL;
      out_vs_q        <= ~VS_POL;
      out_data_q      <= '0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      h_cnt_q         <= h_cnt_d;
      v_cnt_q         <= v_cnt_d;
      rd_req_q        <= rd_req_d;
      hs0_q           <= hs0_d;
      vs0_q           <= vs0_d;
      first0_q        <= first0_d;
      de1_q           <= de1_d;
      hs1_q           <= hs1_d;
      vs1_q           <= vs1_d;
      first1_q        <= first1_d;
      emp1_q          <= emp1_d;
      out_de_q        <= out_de_d;
      out_hs_q        <= out_hs_d;
      out_vs_q        <= out_vs_d;
      out_data_q      <= out_data_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign vout_vs       = vs0_q;
  assign vout_rd_req   = rd_req_q;
  assign vout_width    = H_ACT;
  assign vout_height   = V_ACT;
  assign out_hs        = out_hs_q;
  assign out_vs        = out_vs_q;
  assign out_de        = out_de_q;
  assign out_data      = out_data_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_vout_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vout_timing_gen
//
// Directed bench for vout_timing_gen with a tiny raster:
//   H: 8 active + 2 fp + 2 sync + 2 bp = 14,  V: 4 + 1 + 1 + 1 = 7,
//   so one frame is 98 cycles, vsync sits on line 5, hsync on pixels 10..11.
// A controller model returns an incrementing pixel one cycle after each pop.
// -----------------------------------------------------------------------------
module tb_vout_timing_gen;

  localparam logic [23:0] BLANK = 24'hABCDEF;
  localparam int FRAME = 98;
`ifdef VOUT_UNDERFLOW_STAT_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        vout_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_rdempty;
  logic [23:0] vout_data = '0;
  logic        vout_vs, vout_rd_req;
  logic [11:0] vout_width, vout_height;
  logic        out_hs, out_vs, out_de;
  logic [23:0] out_data;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic [1:0]  dbg_state;

  always #5 vout_clk = ~vout_clk;

  vout_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BLANK_COLOR(BLANK)
  ) dut (
    .vout_clk(vout_clk), .rst(rst), .enable(enable),
    .vout_vs(vout_vs), .vout_rd_req(vout_rd_req), .vout_data(vout_data),
    .fifo_rdempty(fifo_rdempty), .vout_width(vout_width), .vout_height(vout_height),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_data(out_data),
    .underflow(underflow), .underflow_cnt(underflow_cnt), .dbg_state(dbg_state)
  );

  // Controller model: pixel appears the cycle after the pop.
  logic [23:0] model_pix = '0;
  always @(posedge vout_clk) begin
    if (vout_rd_req) begin
      vout_data <= model_pix;
      model_pix <= model_pix + 24'd1;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];
  int exp_pix = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver / monitor ----------------
  // Samples n negedges starting at frame index 0 (counters at 0,0).
  task automatic run_frame(input int n, input int drop_at, input int emp_lo, input int emp_hi,
                           output int rd_cnt, output int vs_cnt, output int vs_first,
                           output int runs, output int bad_run, output int sync_err,
                           output int de_err);
    int run_len, ph, pv;
    logic r1, r2;
    logic [23:0] e;
    rd_cnt = 0; vs_cnt = 0; vs_first = -1; runs = 0; bad_run = 0;
    sync_err = 0; de_err = 0; run_len = 0; r1 = 1'b0; r2 = 1'b0;
    for (int idx = 0; idx < n; idx++) begin
      if (idx == drop_at) enable = 1'b0;
      // output pins reflect the raster position two cycles earlier
      ph = ((idx + FRAME - 2) % FRAME) % 14;
      pv = ((idx + FRAME - 2) % FRAME) / 14;
      if (out_hs !== ((ph >= 10 && ph < 12) ? 1'b0 : 1'b1)) sync_err++;
      if (out_vs !== ((pv == 5) ? 1'b0 : 1'b1)) sync_err++;
      if (out_de !== r2) de_err++;
      if (out_de === 1'b1) begin
        if (exp_q.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("pixel", 32'(out_data), 32'(e));
        end
      end else if (out_data !== 24'd0) de_err++;
      r2 = r1;
      r1 = vout_rd_req;
      if (vout_vs === 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = idx;
      end
      if (vout_rd_req === 1'b1) begin
        fifo_rdempty = (rd_cnt >= emp_lo) && (rd_cnt < emp_hi);
        e = (fifo_rdempty && UF_EN) ? BLANK : 24'(exp_pix);
        exp_q.push_back(e);
        exp_pix++;
        rd_cnt++;
        run_len++;
      end else begin
        fifo_rdempty = 1'b0;
        if (run_len != 0) begin
          runs++;
          if (run_len != 8) bad_run++;
          run_len = 0;
        end
      end
      @(negedge vout_clk);
    end
  endtask

  task automatic wait_blank(input string tag);
    int k;
    k = 0;
    while (dbg_state !== 2'd1 && k < 10) begin
      @(negedge vout_clk);
      k++;
    end
    if (k >= 10) chk(tag, 32'(dbg_state), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"},   32'(vout_rd_req),   32'd0);
    chk({tag, "_vvs"},  32'(vout_vs),       32'd0);
    chk({tag, "_de"},   32'(out_de),        32'd0);
    chk({tag, "_data"}, 32'(out_data),      32'd0);
    chk({tag, "_hs"},   32'(out_hs),        32'd1);
    chk({tag, "_vs"},   32'(out_vs),        32'd1);
    chk({tag, "_uf"},   32'(underflow),     32'd0);
    chk({tag, "_ufc"},  32'(underflow_cnt), 32'd0);
    chk({tag, "_st"},   32'(dbg_state),     32'd0);
  endtask

  initial begin
    int rd, vsc, vsf, runs, br, se, de, idle_err;
    rst = 1'b1; enable = 1'b0; fifo_rdempty = 1'b0;
    repeat (3) @(negedge vout_clk);

    // Reset state and constant outputs.
    chk_reset_vals("reset");
    chk("width",  32'(vout_width),  32'd8);
    chk("height", 32'(vout_height), 32'd4);

    // Idle for 200 cycles with enable low: nothing may move.
    rst = 1'b0;
    idle_err = 0;
    repeat (200) begin
      @(negedge vout_clk);
      if (vout_vs !== 1'b0 || vout_rd_req !== 1'b0 || out_de !== 1'b0 ||
          out_data !== 24'd0 || out_hs !== 1'b1 || out_vs !== 1'b1 ||
          underflow !== 1'b0 || underflow_cnt !== 16'd0 || dbg_state !== 2'd0)
        idle_err++;
    end
    chk("idle_quiet", 32'(idle_err), 32'd0);

    // Startup: first frame is blank, vsync on line 5.
    enable = 1'b1;
    wait_blank("start_timeout");
    run_frame(FRAME, -1, 0, 0, rd, vsc, vsf, runs, br, se, de);
    chk("f1_rd",    32'(rd),  32'd0);
    chk("f1_vscnt", 32'(vsc), 32'd14);
    chk("f1_vsidx", 32'(vsf), 32'd70);
    chk("f1_sync",  32'(se),  32'd0);
    chk("f1_de",    32'(de),  32'd0);
    chk("f1_state", 32'(dbg_state), 32'd2);

    // Second frame: 32 pops in 4 runs of 8, pixels 0..31 out.
    run_frame(FRAME, -1, 0, 0, rd, vsc, vsf, runs, br, se, de);
    chk("f2_rd",     32'(rd),   32'd32);
    chk("f2_runs",   32'(runs), 32'd4);
    chk("f2_badrun", 32'(br),   32'd0);
    chk("f2_vsidx",  32'(vsf),  32'd70);
    chk("f2_sync",   32'(se),   32'd0);
    chk("f2_de",     32'(de),   32'd0);
    chk("f2_uf",     32'(underflow),     32'd0);
    chk("f2_ufc",    32'(underflow_cnt), 32'd0);

    // Third frame: pops 5,6,7 hit an empty FIFO.
    run_frame(FRAME, -1, 5, 8, rd, vsc, vsf, runs, br, se, de);
    chk("f3_rd",  32'(rd), 32'd32);
    chk("f3_de",  32'(de), 32'd0);
    chk("f3_uf",  32'(underflow),     UF_EN ? 32'd1 : 32'd0);
    chk("f3_ufc", 32'(underflow_cnt), UF_EN ? 32'd3 : 32'd0);

    // Fourth frame clean: flag clears, count holds.
    run_frame(FRAME, -1, 0, 0, rd, vsc, vsf, runs, br, se, de);
    chk("f4_uf",  32'(underflow),     32'd0);
    chk("f4_ufc", 32'(underflow_cnt), UF_EN ? 32'd3 : 32'd0);
    chk("f4_sync", 32'(se), 32'd0);

    // Fifth frame: enable drops on line 1, frame still completes.
    run_frame(FRAME, 14, 0, 0, rd, vsc, vsf, runs, br, se, de);
    chk("f5_rd",    32'(rd),   32'd32);
    chk("f5_runs",  32'(runs), 32'd4);
    chk("f5_state", 32'(dbg_state), 32'd0);
    chk("f5_rdreq", 32'(vout_rd_req), 32'd0);
    repeat (3) @(negedge vout_clk);
    chk("f5_de_off", 32'(out_de),  32'd0);
    chk("f5_vvs",    32'(vout_vs), 32'd0);
    chk("sb_drain",  32'(exp_q.size()), 32'd0);

    // Restart, then reset in the middle of an active line.
    enable = 1'b1;
    wait_blank("restart_timeout");
    run_frame(FRAME, -1, 0, 0, rd, vsc, vsf, runs, br, se, de);
    chk("f6_rd", 32'(rd), 32'd0);
    run_frame(18, -1, 0, 0, rd, vsc, vsf, runs, br, se, de);
    chk("f7_rd_pre", 32'(vout_rd_req), 32'd1);
    rst = 1'b1;
    @(negedge vout_clk);
    chk_reset_vals("midrst");
    exp_q.delete();
    rst = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge vout_clk);
    chk("post_rst_st", 32'(dbg_state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
